// File: rtl/lc3_decode_pkg.sv
// Shared types and constants for the LC3 decode stage: opcodes, control-field
// encodings and the Execute control-word layout.
package lc3_decode_pkg;

  localparam int OPCODE_W = 4;
  localparam int E_CTRL_W = 6;
  localparam int W_CTRL_W = 2;
  localparam int M_CTRL_W = 1;

  typedef enum logic [OPCODE_W-1:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_AND = 2'b01,
    ALU_NOT = 2'b10
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    PC1_OFF11 = 2'b00,
    PC1_OFF9  = 2'b01,
    PC1_OFF6  = 2'b10,
    PC1_ZERO  = 2'b11
  } pcsel1_t;

  typedef enum logic [W_CTRL_W-1:0] {
    WB_ALU = 2'b00,
    WB_PC  = 2'b01,
    WB_MEM = 2'b10
  } wb_sel_t;

  // Field order matches the e_control port: {alu, pcsel1, pcsel2, op2sel}
  typedef struct packed {
    alu_ctrl_t alu_control;
    pcsel1_t   pcselect1;
    logic      pcselect2;
    logic      op2select;
  } e_control_t;

endpackage

// File: rtl/decode_ctrl_lut.sv
// Combinational opcode -> Execute/Writeback/Memory control lookup, plus a flag
// for opcodes this pipeline does not implement.
module decode_ctrl_lut
  import lc3_decode_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                ir_bit5,
  output e_control_t          e_control,
  output wb_sel_t             w_control,
  output logic                mem_control,
  output logic                illegal
);

  opcode_t op;
  assign op = opcode_t'(opcode);

  always_comb begin
    e_control   = '{alu_control: ALU_ADD, pcselect1: PC1_OFF11,
                    pcselect2: 1'b0, op2select: 1'b1};
    w_control   = WB_ALU;
    mem_control = 1'b0;
    illegal     = 1'b0;
    case (op)
      // Register-mode ADD/AND (bit 5 clear) select VSR2; immediate selects imm5
      OP_ADD: e_control.op2select = ~ir_bit5;
      OP_AND: begin
        e_control.alu_control = ALU_AND;
        e_control.op2select   = ~ir_bit5;
      end
      OP_NOT: e_control.alu_control = ALU_NOT;
      OP_BR: begin
        e_control.pcselect1 = PC1_OFF9;
        e_control.pcselect2 = 1'b1;
      end
      OP_JMP: e_control.pcselect1 = PC1_ZERO;
      OP_LD: begin
        e_control.pcselect1 = PC1_OFF9;
        e_control.pcselect2 = 1'b1;
        w_control           = WB_MEM;
      end
      OP_LDR: begin
        e_control.pcselect1 = PC1_OFF6;
        w_control           = WB_MEM;
      end
      OP_LDI: begin
        e_control.pcselect1 = PC1_OFF9;
        e_control.pcselect2 = 1'b1;
        w_control           = WB_MEM;
        mem_control         = 1'b1;
      end
      OP_LEA: begin
        e_control.pcselect1 = PC1_OFF9;
        e_control.pcselect2 = 1'b1;
        w_control           = WB_PC;
      end
      OP_ST: begin
        e_control.pcselect1 = PC1_OFF9;
        e_control.pcselect2 = 1'b1;
      end
      OP_STR: e_control.pcselect1 = PC1_OFF6;
      OP_STI: begin
        e_control.pcselect1 = PC1_OFF9;
        e_control.pcselect2 = 1'b1;
        mem_control         = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// LC3 Decode stage: registers IR/NPC and the decoded control words on enable.
// Define LC3_DECODE_ILLEGAL_CHECK_EN to register an unsupported-opcode flag.
module decode_stage
  import lc3_decode_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] NPC_RST_VAL = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_decode,
  input  logic [DATA_WIDTH-1:0] instr_dout,
  input  logic [DATA_WIDTH-1:0] npc_in,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [DATA_WIDTH-1:0] npc_out,
  output logic [E_CTRL_W-1:0]   e_control,
  output logic [W_CTRL_W-1:0]   w_control,
  output logic [M_CTRL_W-1:0]   mem_control,
  output logic                  valid_out,
  output logic                  illegal_instr
);

  if (DATA_WIDTH != 16) begin : g_width_check
    $error("decode_stage: DATA_WIDTH must be 16 for the LC3 ISA");
  end

  e_control_t            lut_e;
  wb_sel_t               lut_w;
  logic                  lut_mem;
  logic                  lut_illegal;

  logic [DATA_WIDTH-1:0] ir_reg;
  logic [DATA_WIDTH-1:0] npc_reg;
  logic [E_CTRL_W-1:0]   e_ctrl_reg, e_ctrl_next;
  logic [W_CTRL_W-1:0]   w_ctrl_reg, w_ctrl_next;
  logic [M_CTRL_W-1:0]   mem_ctrl_reg, mem_ctrl_next;
  logic                  valid_reg;

  decode_ctrl_lut u_lut (
    .opcode      (instr_dout[DATA_WIDTH-1 -: OPCODE_W]),
    .ir_bit5     (instr_dout[5]),
    .e_control   (lut_e),
    .w_control   (lut_w),
    .mem_control (lut_mem),
    .illegal     (lut_illegal)
  );

  // Unsupported opcodes still capture IR/NPC but issue no control activity
  always_comb begin
    e_ctrl_next   = lut_e;
    w_ctrl_next   = lut_w;
    mem_ctrl_next = lut_mem;
    if (lut_illegal) begin
      e_ctrl_next   = '0;
      w_ctrl_next   = '0;
      mem_ctrl_next = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ir_reg       <= '0;
      npc_reg      <= NPC_RST_VAL;
      e_ctrl_reg   <= '0;
      w_ctrl_reg   <= '0;
      mem_ctrl_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      valid_reg <= enable_decode;
      if (enable_decode) begin
        ir_reg       <= instr_dout;
        npc_reg      <= npc_in;
        e_ctrl_reg   <= e_ctrl_next;
        w_ctrl_reg   <= w_ctrl_next;
        mem_ctrl_reg <= mem_ctrl_next;
      end
    end
  end

`ifdef LC3_DECODE_ILLEGAL_CHECK_EN
  logic illegal_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_reg <= 1'b0;
    end else if (enable_decode) begin
      illegal_reg <= lut_illegal;
    end
  end

  assign illegal_instr = illegal_reg;
`else
  assign illegal_instr = 1'b0;
`endif

  assign ir          = ir_reg;
  assign npc_out     = npc_reg;
  assign e_control   = e_ctrl_reg;
  assign w_control   = w_ctrl_reg;
  assign mem_control = mem_ctrl_reg;
  assign valid_out   = valid_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: opcode-table model checked every cycle
// plus directed literal expectations.
module tb_decode_stage;

  localparam logic [15:0] NPC_RST = 16'h0200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_decode = 1'b0;
  logic [15:0] instr_dout = '0;
  logic [15:0] npc_in = '0;
  logic [15:0] ir;
  logic [15:0] npc_out;
  logic [5:0]  e_control;
  logic [1:0]  w_control;
  logic [0:0]  mem_control;
  logic        valid_out;
  logic        illegal_instr;

  int total = 0;
  int bad = 0;

  decode_stage #(.DATA_WIDTH(16), .NPC_RST_VAL(NPC_RST)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .instr_dout    (instr_dout),
    .npc_in        (npc_in),
    .ir            (ir),
    .npc_out       (npc_out),
    .e_control     (e_control),
    .w_control     (w_control),
    .mem_control   (mem_control),
    .valid_out     (valid_out),
    .illegal_instr (illegal_instr)
  );

  always #5 clock = ~clock;

`ifdef LC3_DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  // Returns {illegal, e_control[5:0], w_control[1:0], mem_control} from the ISA table
  function automatic logic [9:0] decode_ref(input logic [15:0] instr);
    logic [1:0] alu, pc1, wb;
    logic       pc2, op2, mem, ill;
    alu = 2'b00; pc1 = 2'b00; pc2 = 1'b0; op2 = 1'b1; wb = 2'b00; mem = 1'b0; ill = 1'b0;
    case (instr[15:12])
      4'h1: op2 = ~instr[5];
      4'h5: begin alu = 2'b01; op2 = ~instr[5]; end
      4'h9: alu = 2'b10;
      4'h0: begin pc1 = 2'b01; pc2 = 1'b1; end
      4'hC: pc1 = 2'b11;
      4'h2: begin pc1 = 2'b01; pc2 = 1'b1; wb = 2'b10; end
      4'h6: begin pc1 = 2'b10; wb = 2'b10; end
      4'hA: begin pc1 = 2'b01; pc2 = 1'b1; wb = 2'b10; mem = 1'b1; end
      4'hE: begin pc1 = 2'b01; pc2 = 1'b1; wb = 2'b01; end
      4'h3: begin pc1 = 2'b01; pc2 = 1'b1; end
      4'h7: pc1 = 2'b10;
      4'hB: begin pc1 = 2'b01; pc2 = 1'b1; mem = 1'b1; end
      default: begin ill = 1'b1; op2 = 1'b0; end
    endcase
    return {ill, alu, pc1, pc2, op2, wb, mem};
  endfunction

  logic [15:0] m_ir, m_npc;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_mem, m_valid, m_ill, m_known;
  logic [9:0]  m_dec;

  initial m_known = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_ir = '0; m_npc = NPC_RST; m_e = '0; m_w = '0; m_mem = 1'b0;
      m_valid = 1'b0; m_ill = 1'b0; m_known = 1'b1;
    end else if (enable_decode) begin
      m_dec   = decode_ref(instr_dout);
      m_ir    = instr_dout;
      m_npc   = npc_in;
      m_e     = m_dec[8:3];
      m_w     = m_dec[2:1];
      m_mem   = m_dec[0];
      m_ill   = ILL_EN & m_dec[9];
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (m_known) begin
      chk("m_ir", ir, m_ir);
      chk("m_npc", npc_out, m_npc);
      chk("m_e_control", 16'(e_control), 16'(m_e));
      chk("m_w_control", 16'(w_control), 16'(m_w));
      chk("m_mem_control", 16'(mem_control), 16'(m_mem));
      chk("m_valid", 16'(valid_out), 16'(m_valid));
      chk("m_illegal", 16'(illegal_instr), 16'(m_ill));
    end
  end

  task automatic cyc(input logic r, input logic en, input logic [15:0] ins, input logic [15:0] npc);
    reset = r; enable_decode = en; instr_dout = ins; npc_in = npc;
    @(negedge clock);
    $display("txn rst=%0b en=%0b instr=%h npc=%h -> ir=%h npc_out=%h e=%b w=%b mem=%b v=%b ill=%b",
             r, en, ins, npc, ir, npc_out, e_control, w_control, mem_control, valid_out, illegal_instr);
  endtask

  initial begin
    @(negedge clock);
    // Reset held two cycles with a live instruction on the bus
    cyc(1'b1, 1'b1, 16'h1042, 16'h1234);
    cyc(1'b1, 1'b1, 16'h1042, 16'h1234);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_npc", npc_out, NPC_RST);
    chk("rst_e", 16'(e_control), 16'h0000);
    chk("rst_valid", 16'(valid_out), 16'h0000);

    cyc(1'b0, 1'b1, 16'h1261, 16'h3001);
    chk("add_imm_ir", ir, 16'h1261);
    chk("add_imm_npc", npc_out, 16'h3001);
    chk("add_imm_e", 16'(e_control), 16'b000000);
    chk("add_imm_valid", 16'(valid_out), 16'h0001);

    cyc(1'b0, 1'b1, 16'h5042, 16'h3002);
    chk("and_reg_e", 16'(e_control), 16'b010001);
    chk("and_reg_w", 16'(w_control), 16'b00);
    cyc(1'b0, 1'b1, 16'hA5FE, 16'h3003);
    chk("ldi_e", 16'(e_control), 16'b000111);
    chk("ldi_w", 16'(w_control), 16'b10);
    chk("ldi_mem", 16'(mem_control), 16'h0001);

    cyc(1'b0, 1'b1, 16'h2402, 16'h3004);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 16'hFFFF, 16'hBEEF);
      chk("stall_ir", ir, 16'h2402);
      chk("stall_w", 16'(w_control), 16'b10);
      chk("stall_valid", 16'(valid_out), 16'h0000);
    end

    cyc(1'b0, 1'b1, 16'hF025, 16'h3005);
    chk("trap_ir", ir, 16'hF025);
    chk("trap_e", 16'(e_control), 16'h0000);
    chk("trap_ill", 16'(illegal_instr), 16'(ILL_EN));
    cyc(1'b0, 1'b0, 16'h1261, 16'h3006);
    chk("trap_ill_hold", 16'(illegal_instr), 16'(ILL_EN));

    cyc(1'b0, 1'b1, 16'h927F, 16'h3007);
    chk("not_e", 16'(e_control), 16'b100001);
    chk("not_ill_clear", 16'(illegal_instr), 16'h0000);
    cyc(1'b0, 1'b1, 16'hC1C0, 16'h3008);
    chk("jmp_e", 16'(e_control), 16'b001101);
    cyc(1'b0, 1'b1, 16'h6283, 16'hFFFF);
    chk("ldr_e", 16'(e_control), 16'b001001);
    chk("npc_ffff", npc_out, 16'hFFFF);
    cyc(1'b0, 1'b1, 16'hE3FF, 16'h300A);
    chk("lea_w", 16'(w_control), 16'b01);

    // Reset wins over a simultaneous enable
    cyc(1'b1, 1'b1, 16'hE3FF, 16'h4000);
    chk("midrst_ir", ir, 16'h0000);
    chk("midrst_w", 16'(w_control), 16'b00);
    chk("midrst_npc", npc_out, NPC_RST);
    chk("midrst_valid", 16'(valid_out), 16'h0000);

    // Sweep every opcode with random operand bits and occasional stalls
    for (int i = 0; i < 48; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom_range(0, 16'hFFFF));
      ins[15:12] = 4'(i % 16);
      cyc(1'b0, (i % 5) != 4, ins, 16'($urandom_range(0, 16'hFFFF)));
    end

    cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
